execute_stage: RTL and testbench

Execute stage of the bf8b 8-bit core, directly upstream of writeback. Accepts one decoded instruction at a time, reads operands from the packed register file that writeback exports, and computes the result. Performs the single data-memory access for LOD/STR over a req/ack handshake. Delivers exactly one `wb_en` pulse per instruction, carrying op, destination and value.

---
 rtl/bf8b_pkg.sv | 24 ++
 rtl/exec_alu.sv | 23 ++
 rtl/execute_stage.sv | 134 +++++++++++++
 tb/tb_execute_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bf8b_pkg.sv
// Shared definitions for the bf8b 8-bit core: opcodes, execute FSM states and
// register-file geometry. Writeback imports the same package.
package bf8b_pkg;
  localparam int REG_W  = 8;
  localparam int REG_N  = 16;
  localparam int RF_W   = REG_W * REG_N;
  localparam int OP_W   = 4;
  localparam int RIDX_W = 4;

  // Kept as plain constants rather than an enum so undefined codes pass through.
  localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OP_W-1:0] OP_LOD  = 4'b0001;
  localparam logic [OP_W-1:0] OP_STR  = 4'b0010;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0011;
  localparam logic [OP_W-1:0] OP_ADDI = 4'b0100;
  localparam logic [OP_W-1:0] OP_LODI = 4'b0101;
  localparam logic [OP_W-1:0] OP_NAND = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WB   = 2'd2
  } exec_state_e;
endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for the execute stage. sum is the 9-bit add result so the
// caller can derive carry; result is zero for ops the ALU does not compute.
module exec_alu
  import bf8b_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [REG_W-1:0] a,
  input  logic [REG_W-1:0] b,
  input  logic [REG_W-1:0] imm,
  output logic [REG_W-1:0] result,
  output logic [REG_W:0]   sum
);
  always_comb begin
    sum    = {1'b0, a} + {1'b0, (op == OP_ADDI) ? imm : b};
    result = '0;
    case (op)
      OP_ADD, OP_ADDI: result = sum[REG_W-1:0];
      OP_NAND:         result = ~(a & b);
      OP_LODI:         result = imm;
      default:         result = '0;
    endcase
  end
endmodule

// File: rtl/execute_stage.sv
// bf8b execute stage: IDLE -> (MEM) -> WB, one wb_en pulse per instruction.
// Define EXEC_FLAGS_EN to add the zero/carry flag ports.
module execute_stage
  import bf8b_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [OP_W-1:0]   op,
  input  logic [RIDX_W-1:0] rd,
  input  logic [RIDX_W-1:0] rs,
  input  logic [REG_W-1:0]  imm,
  input  logic [RF_W-1:0]   regs,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [REG_W-1:0]  mem_addr,
  output logic [REG_W-1:0]  mem_wdata,
  input  logic              mem_ack,
  input  logic [REG_W-1:0]  mem_rdata,
  output logic              wb_en,
  output logic [OP_W-1:0]   wb_op,
  output logic [RIDX_W-1:0] wb_reg_addr,
`ifdef EXEC_FLAGS_EN
  output logic              zero,
  output logic              carry,
`endif
  output logic [REG_W-1:0]  wb_val
);
  exec_state_e       state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [RIDX_W-1:0] rd_q, rd_d;
  logic [REG_W-1:0]  imm_q, imm_d, a_q, a_d, b_q, b_d, rdata_q, rdata_d;
  logic [REG_W-1:0]  alu_res;
  logic [REG_W:0]    alu_sum;

  exec_alu u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .result (alu_res),
    .sum    (alu_sum)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    a_d     = a_q;
    b_d     = b_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: if (en) begin
        op_d    = op;
        rd_d    = rd;
        imm_d   = imm;
        a_d     = regs[{rd, 3'b000} +: REG_W];
        b_d     = regs[{rs, 3'b000} +: REG_W];
        state_d = (op == OP_LOD || op == OP_STR) ? ST_MEM : ST_WB;
      end
      ST_MEM: if (mem_ack) begin
        rdata_d = mem_rdata;
        state_d = ST_WB;
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are gated by state so they read zero whenever they are not valid.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    mem_req     = (state_q == ST_MEM);
    mem_we      = mem_req && (op_q == OP_STR);
    mem_addr    = mem_req ? b_q : '0;
    mem_wdata   = mem_req ? a_q : '0;
    wb_en       = (state_q == ST_WB);
    wb_op       = wb_en ? op_q : '0;
    wb_reg_addr = wb_en ? rd_q : '0;
    wb_val      = '0;
    if (wb_en) wb_val = (op_q == OP_LOD) ? rdata_q : alu_res;
  end

`ifdef EXEC_FLAGS_EN
  logic zero_q, zero_d, carry_q, carry_d;

  always_comb begin
    zero_d  = zero_q;
    carry_d = carry_q;
    if (wb_en && (op_q == OP_ADD || op_q == OP_ADDI || op_q == OP_NAND)) begin
      zero_d  = (alu_res == '0);
      carry_d = (op_q == OP_NAND) ? 1'b0 : alu_sum[REG_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign zero  = zero_q;
  assign carry = carry_q;
`else
  logic unused_sum;
  assign unused_sum = ^alu_sum;
`endif
endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: drivers push expected writebacks,
// a negedge monitor pops and compares whenever wb_en is seen.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  op = '0, rd = '0, rs = '0;
  logic [7:0]  imm = '0;
  logic [127:0] regs = '0;
  logic        busy, mem_req, mem_we, mem_ack = 1'b0;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata = '0, wb_val;
  logic        wb_en;
  logic [3:0]  wb_op, wb_reg_addr;
`ifdef EXEC_FLAGS_EN
  logic        zero, carry;
`endif

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .rd(rd), .rs(rs), .imm(imm),
    .regs(regs), .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_op(wb_op),
    .wb_reg_addr(wb_reg_addr),
`ifdef EXEC_FLAGS_EN
    .zero(zero), .carry(carry),
`endif
    .wb_val(wb_val)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] op;
    logic [3:0] rd;
    logic [7:0] val;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every wb_en cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (wb_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_wb_en: got wb_en at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_op", {28'd0, wb_op}, {28'd0, e.op});
        chk("wb_reg_addr", {28'd0, wb_reg_addr}, {28'd0, e.rd});
        chk("wb_val", {24'd0, wb_val}, {24'd0, e.val});
        chk("wb_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic setr(input int i, input logic [7:0] v);
    regs[8*i +: 8] = v;
  endtask

  task automatic push(input logic [3:0] o, input logic [3:0] r, input logic [7:0] v, input int c);
    exp_t e;
    e.op = o; e.rd = r; e.val = v; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Non-memory op: wb_en expected in the cycle right after the accepting edge.
  task automatic issue(input logic [3:0] o, input logic [3:0] d, input logic [3:0] s,
                       input logic [7:0] im, input logic [7:0] ev, input bit clobber);
    @(posedge clk); #1;
    en = 1'b1; op = o; rd = d; rs = s; imm = im;
    push(o, d, ev, cyc + 1);
    @(posedge clk); #1;
    en = 1'b0;
    if (clobber) regs = ~regs;
  endtask

  task automatic mem_op(input logic [3:0] o, input logic [3:0] d, input logic [3:0] s,
                        input int waits, input logic [7:0] rdata, input logic [7:0] ev,
                        input logic [7:0] ea, input logic ewe, input logic [7:0] ewd,
                        input bit inject_en);
    @(posedge clk); #1;
    en = 1'b1; op = o; rd = d; rs = s; imm = 8'h00;
    @(posedge clk); #1;
    en = 1'b0;
    chk("mem_req_rise", {31'd0, mem_req}, 32'd1);
    chk("mem_addr", {24'd0, mem_addr}, {24'd0, ea});
    chk("mem_we", {31'd0, mem_we}, {31'd0, ewe});
    if (ewe) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, ewd});
    for (int i = 0; i < waits; i++) begin
      if (inject_en && i == 0) begin
        en = 1'b1; op = 4'h3; rd = 4'h1; rs = 4'h2;
      end
      @(posedge clk); #1;
      en = 1'b0;
      chk("mem_req_hold", {31'd0, mem_req}, 32'd1);
      chk("mem_addr_hold", {24'd0, mem_addr}, {24'd0, ea});
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    push(o, d, ev, cyc + 1);
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    chk("mem_req_drop", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    setr(1, 8'hF0); setr(2, 8'h20); setr(3, 8'hFF); setr(4, 8'hFF);
    setr(6, 8'h40); setr(7, 8'h11); setr(8, 8'h80); setr(9, 8'h7F);
    setr(10, 8'h03); setr(11, 8'h04);
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_outputs", {mem_req, mem_we, wb_en, mem_addr, mem_wdata, wb_op, wb_reg_addr},
        32'd0);
    chk("rst_wb_val", {24'd0, wb_val}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Stray acks while idle must do nothing.
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("idle_ack_busy", {31'd0, busy}, 32'd0);
    chk("idle_ack_req", {31'd0, mem_req}, 32'd0);

    issue(4'h3, 4'd1, 4'd2, 8'h00, 8'h10, 1'b0);       // ADD F0+20
    chk("busy_in_wb", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("busy_after_wb", {31'd0, busy}, 32'd0);
`ifdef EXEC_FLAGS_EN
    chk("carry_add", {31'd0, carry}, 32'd1);
    chk("zero_add", {31'd0, zero}, 32'd0);
`endif
    issue(4'h6, 4'd3, 4'd4, 8'h00, 8'h00, 1'b0);       // NAND FF,FF
    @(posedge clk); #1;
`ifdef EXEC_FLAGS_EN
    chk("zero_nand", {31'd0, zero}, 32'd1);
    chk("carry_nand", {31'd0, carry}, 32'd0);
`endif
    issue(4'h5, 4'd12, 4'd0, 8'h5A, 8'h5A, 1'b0);      // LODI
    issue(4'h4, 4'd9, 4'd0, 8'h01, 8'h80, 1'b0);       // ADDI 7F+1
    issue(4'h0, 4'd2, 4'd3, 8'hAA, 8'h00, 1'b0);       // NOP
    issue(4'hF, 4'd4, 4'd5, 8'hAA, 8'h00, 1'b0);       // undefined code
    issue(4'h3, 4'd10, 4'd11, 8'h00, 8'h07, 1'b1);     // ADD with regs clobbered in flight
    regs = ~regs;

    mem_op(4'h1, 4'd5, 4'd6, 3, 8'hC3, 8'hC3, 8'h40, 1'b0, 8'h00, 1'b0);  // LOD, 3 waits
    mem_op(4'h2, 4'd7, 4'd8, 1, 8'h99, 8'h00, 8'h80, 1'b1, 8'h11, 1'b1);  // STR, en injected
    mem_op(4'h1, 4'd5, 4'd8, 0, 8'h3C, 8'h3C, 8'h80, 1'b0, 8'h00, 1'b0);  // LOD, ack at once

    // Reset in the middle of MEM abandons the access.
    @(posedge clk); #1;
    en = 1'b1; op = 4'h1; rd = 4'd5; rs = 4'd6;
    @(posedge clk); #1;
    en = 1'b0;
    chk("pre_reset_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_req_drop", {31'd0, mem_req}, 32'd0);
    chk("async_busy_drop", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(4'h3, 4'd1, 4'd2, 8'h00, 8'h10, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
